// File: rtl/ex_mdu_seq.sv
// ex_mdu_seq: sequential RV32M multiply/divide unit.
// Multiply uses radix-2 shift-add on operand magnitudes with sign fix-up;
// divide uses restoring division on magnitudes.
// Build option: define MDU_DIV_EN to compile in the divide path. Without it,
// ops 4-7 complete in one cycle with a zero result and no divider exists.
module ex_mdu_seq #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] rs1_i,
    input  logic [DW-1:0] rs2_i,
    input  logic [4:0]    wd_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          stall_o,
    output logic          done_o,
    output logic          wreg_o,
    output logic [4:0]    wd_o,
    output logic [DW-1:0] data_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_reg;
    logic [5:0]        cnt_reg;
    logic [2:0]        op_reg;
    logic [4:0]        wd_reg;
    logic              neg_reg;      // product / quotient must be negated
    logic [2*DW-1:0]   acc_reg;      // {hi, lo}: product, or {remainder, quotient}
    logic [DW-1:0]     opb_reg;      // multiplicand / divisor magnitude
    logic [DW-1:0]     data_reg;
    logic [4:0]        wd_out_reg;

    // Operand signedness and magnitudes at accept time (RV32M rules).
    logic          rs1_signed, rs2_signed, a_neg, b_neg;
    logic [DW-1:0] a_mag, b_mag;
    always_comb begin
        rs1_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        rs2_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        a_neg      = rs1_signed & rs1_i[DW-1];
        b_neg      = rs2_signed & rs2_i[DW-1];
        a_mag      = a_neg ? (~rs1_i + 1'b1) : rs1_i;
        b_mag      = b_neg ? (~rs2_i + 1'b1) : rs2_i;
    end

    // One shift-add multiply step: add multiplicand into hi when lo[0] set, then shift right.
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_next, prod_fix;
    logic [DW-1:0]   mul_res;
    always_comb begin
        mul_sum  = acc_reg[0] ? ({1'b0, acc_reg[2*DW-1:DW]} + {1'b0, opb_reg})
                              : {1'b0, acc_reg[2*DW-1:DW]};
        mul_next = {mul_sum, acc_reg[DW-1:1]};
        prod_fix = neg_reg ? (~acc_reg + 1'b1) : acc_reg;
        mul_res  = (op_reg[1:0] == 2'd0) ? prod_fix[DW-1:0] : prod_fix[2*DW-1:DW];
    end

`ifdef MDU_DIV_EN
    logic            rneg_reg;       // remainder must be negated (follows rs1 sign)
    logic [DW:0]     div_diff;
    logic [2*DW-1:0] div_next;
    logic [DW-1:0]   quo_fix, rem_fix, div_res;
    logic            div_ovf;
    // One restoring step: shift left, trial-subtract divisor from the partial remainder.
    always_comb begin
        div_diff = acc_reg[2*DW-1:DW-1] - {1'b0, opb_reg};
        div_next = div_diff[DW] ? {acc_reg[2*DW-2:0], 1'b0}
                                : {div_diff[DW-1:0], acc_reg[DW-2:0], 1'b1};
        quo_fix  = neg_reg  ? (~acc_reg[DW-1:0] + 1'b1) : acc_reg[DW-1:0];
        rem_fix  = rneg_reg ? (~acc_reg[2*DW-1:DW] + 1'b1) : acc_reg[2*DW-1:DW];
        div_res  = op_reg[1] ? rem_fix : quo_fix;
        div_ovf  = ~op_i[0] && (rs1_i == {1'b1, {(DW-1){1'b0}}}) && (rs2_i == {DW{1'b1}});
    end
`endif

    // Control FSM plus datapath registers; result registers are cleared outside DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            wd_reg     <= '0;
            neg_reg    <= 1'b0;
            acc_reg    <= '0;
            opb_reg    <= '0;
            data_reg   <= '0;
            wd_out_reg <= '0;
`ifdef MDU_DIV_EN
            rneg_reg   <= 1'b0;
`endif
        end else begin
            data_reg   <= '0;
            wd_out_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_reg    <= op_i;
                        wd_reg    <= wd_i;
                        cnt_reg   <= '0;
                        neg_reg   <= a_neg ^ b_neg;
                        acc_reg   <= {{DW{1'b0}}, a_mag};
                        opb_reg   <= b_mag;
                        state_reg <= S_CALC;
`ifdef MDU_DIV_EN
                        rneg_reg  <= a_neg;
                        if (op_i[2]) begin
                            if (rs2_i == '0) begin
                                state_reg  <= S_DONE;
                                wd_out_reg <= wd_i;
                                data_reg   <= op_i[1] ? rs1_i : {DW{1'b1}};
                            end else if (div_ovf) begin
                                state_reg  <= S_DONE;
                                wd_out_reg <= wd_i;
                                data_reg   <= op_i[1] ? '0 : {1'b1, {(DW-1){1'b0}}};
                            end
                        end
`else
                        if (op_i[2]) begin
                            state_reg  <= S_DONE;
                            wd_out_reg <= wd_i;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state_reg <= S_IDLE;
                    end else begin
`ifdef MDU_DIV_EN
                        acc_reg <= op_reg[2] ? div_next : mul_next;
`else
                        acc_reg <= mul_next;
`endif
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == 6'd31) state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush_i) begin
                        state_reg <= S_IDLE;
                    end else begin
`ifdef MDU_DIV_EN
                        data_reg <= op_reg[2] ? div_res : mul_res;
`else
                        data_reg <= mul_res;
`endif
                        wd_out_reg <= wd_reg;
                        state_reg  <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy_o  = (state_reg != S_IDLE);
        done_o  = (state_reg == S_DONE);
        wreg_o  = done_o;
        stall_o = (start_i && (state_reg == S_IDLE) && !flush_i) ||
                  (busy_o && (state_reg != S_DONE));
        wd_o    = wd_out_reg;
        data_o  = data_reg;
    end

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Scoreboard bench for ex_mdu_seq: stimulus pushes expected results, a
// monitor pops and compares on every done_o pulse.
module tb_ex_mdu_seq;

    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  wd_i;
    logic        busy_o, stall_o, done_o, wreg_o;
    logic [4:0]  wd_o;
    logic [31:0] data_o;

    ex_mdu_seq #(.DW(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .wd_i(wd_i), .flush_i(flush_i),
        .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .wreg_o(wreg_o),
        .wd_o(wd_o), .data_o(data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  wd;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: data=0x%08h wd=%0d with no pending op", data_o, wd_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data", data_o, e.data);
                chk("wd", {27'd0, wd_o}, {27'd0, e.wd});
                chk("wreg", {31'd0, wreg_o}, 32'd1);
                chk("latency", cyc - e.issue, e.lat);
                $display("txn: data=0x%08h wd=%0d latency=%0d", data_o, wd_o, cyc - e.issue);
            end
        end
    end

    // Issue one op; optionally check stall_o per cycle and poke start_i while busy.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic [31:0] exp_d, input int lat,
                         input bit chk_stall);
        exp_t e;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; wd_i = wd;
        e.data = exp_d; e.wd = wd; e.lat = lat; e.issue = cyc;
        sb.push_back(e);
        if (chk_stall) begin
            #1 chk("stall_c0", {31'd0, stall_o}, 32'd1);
        end
        @(negedge clk);
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; wd_i = 5'd31;
        if (chk_stall) begin
            for (int k = 1; k <= 34; k++) begin
                chk($sformatf("stall_c%0d", k), {31'd0, stall_o}, (k <= 33) ? 32'd1 : 32'd0);
                if (k == 5) begin
                    start_i = 1'b1; op_i = 3'd3; rs1_i = 32'h1234_5678; wd_i = 5'd9;
                end else begin
                    start_i = 1'b0;
                end
                if (k < 34) @(negedge clk);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d ops still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
        rs1_i = '0; rs2_i = '0; wd_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst_wd", {27'd0, wd_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        rst = 1'b0;

        // Multiply vectors
        issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, 1'b1); drain();
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34, 1'b0); drain();
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 34, 1'b0); drain();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 34, 1'b0); drain();
        issue(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd5, 32'h2345_6780, 34, 1'b0); drain();
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 34, 1'b0); drain();

        // Divide vectors (zero-result single-cycle when the divider is not built)
        issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  DIV_ON ? 32'hFFFF_FFFD : 32'h0, DIV_ON ? 34 : 1, 1'b0); drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  DIV_ON ? 32'hFFFF_FFFF : 32'h0, DIV_ON ? 34 : 1, 1'b0); drain();
        issue(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd9,  DIV_ON ? 32'hFFFF_FFFF : 32'h0, 1, 1'b0); drain();
        issue(3'd7, 32'h0000_0005, 32'h0000_0000, 5'd10, DIV_ON ? 32'h0000_0005 : 32'h0, 1, 1'b0); drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, DIV_ON ? 32'h8000_0000 : 32'h0, 1, 1'b0); drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1, 1'b0); drain();
        issue(3'd4, 32'h0000_000A, 32'h0000_0003, 5'd13, DIV_ON ? 32'h0000_0003 : 32'h0, DIV_ON ? 34 : 1, 1'b0); drain();
        issue(3'd5, 32'h0000_0064, 32'h0000_0007, 5'd14, DIV_ON ? 32'h0000_000E : 32'h0, DIV_ON ? 34 : 1, 1'b0); drain();
        issue(3'd7, 32'h0000_0064, 32'h0000_0007, 5'd15, DIV_ON ? 32'h0000_0002 : 32'h0, DIV_ON ? 34 : 1, 1'b0); drain();

        // Flush mid-CALC: no done pulse, then a fresh op completes
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5; wd_i = 5'd20;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_done", {31'd0, done_o}, 32'd0);
        issue(3'd0, 32'd6, 32'd7, 5'd21, 32'd42, 34, 1'b0); drain();

        // Flush and start together in IDLE: start is not accepted
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2; wd_i = 5'd22;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start_busy", {31'd0, busy_o}, 32'd0);

        // Reset during CALC with start held high, then accept from IDLE
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; wd_i = 5'd23;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstcalc_busy", {31'd0, busy_o}, 32'd0);
        chk("rstcalc_done", {31'd0, done_o}, 32'd0);
        chk("rstcalc_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rstcalc_wd", {27'd0, wd_o}, 32'd0);
        chk("rstcalc_data", data_o, 32'd0);
        begin
            exp_t e;
            rst = 1'b0;
            op_i = 3'd0; rs1_i = 32'd11; rs2_i = 32'd13; wd_i = 5'd24;
            e.data = 32'd143; e.wd = 5'd24; e.lat = 34; e.issue = cyc;
            sb.push_back(e);
            @(negedge clk);
            start_i = 1'b0;
        end
        drain();
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
